// File: rtl/gray_cnt_pkg.sv
// Shared definitions for the Gray-counter arbiter slice.
//   op_e       : command encodings carried on OPA/OPB
//   state_e    : sequencer FSM states
//   gray4_next : successor of a 4-bit Gray code value (wraps 1000 -> 0000)
package gray_cnt_pkg;

  localparam int unsigned CNT_W = 4;

  // Value the counter jumps to on a preset strobe.
  localparam logic [CNT_W-1:0] GRAY_PRESET = 4'b1111;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'b00,
    OP_PRESET = 2'b01,
    OP_LOAD   = 2'b10,
    OP_STEP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_GRANT = 2'b01,
    S_EXEC  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

  function automatic logic [CNT_W-1:0] gray4_next(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] n;
    case (g)
      4'b0000: n = 4'b0001;
      4'b0001: n = 4'b0011;
      4'b0011: n = 4'b0010;
      4'b0010: n = 4'b0110;
      4'b0110: n = 4'b0111;
      4'b0111: n = 4'b0101;
      4'b0101: n = 4'b0100;
      4'b0100: n = 4'b1100;
      4'b1100: n = 4'b1101;
      4'b1101: n = 4'b1111;
      4'b1111: n = 4'b1110;
      4'b1110: n = 4'b1010;
      4'b1010: n = 4'b1011;
      4'b1011: n = 4'b1001;
      4'b1001: n = 4'b1000;
      4'b1000: n = 4'b0000;
      default: n = 4'b0000;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/gray4_cnt.sv
// 4-bit Gray-code up counter with synchronous preset, clear, parallel load
// and count enable.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   ps_i  : preset to 1111        (highest priority)
//   cs_i  : clear to 0000
//   ld_i  : load d_i
//   en_i  : advance one Gray step (lowest priority)
//   d_i   : parallel load value
//   q_o   : current Gray count
module gray4_cnt
  import gray_cnt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ps_i,
  input  logic             cs_i,
  input  logic             ld_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] d_i,
  output logic [CNT_W-1:0] q_o
);

  logic [CNT_W-1:0] q_q;
  logic [CNT_W-1:0] q_d;

  always_comb begin
    // NOTE: assign every always_comb output a default first so no path leaves it unassigned (latch).
    q_d = q_q;
    if (ps_i)      q_d = GRAY_PRESET;
    else if (cs_i) q_d = '0;
    else if (ld_i) q_d = d_i;
    else if (en_i) q_d = gray4_next(q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/gray_cnt_arb.sv
// Two-requester round-robin arbiter and sequencer driving a shared Gray
// counter. Each handshake carries one command (CLEAR, PRESET, LOAD, STEP N).
//   CLK          : rising-edge clock
//   RN           : asynchronous active-low reset
//   REQA/REQB    : requests, held with command stable until granted
//   OPA/OPB      : command opcodes (see op_e)
//   ARGA/ARGB    : LOAD value, or STEP count minus one
//   HOLD         : freezes an executing STEP
//   GNTA/GNTB    : one-cycle grant pulse; command captured that cycle
//   DONE         : one-cycle completion pulse
//   DONE_ID      : requester that completed (0=A, 1=B)
//   BUSY         : sequencer not in IDLE
//   Q            : counter value
module gray_cnt_arb
  import gray_cnt_pkg::*;
(
  input  logic             CLK,
  input  logic             RN,
  input  logic             REQA,
  input  logic             REQB,
  input  logic [1:0]       OPA,
  input  logic [1:0]       OPB,
  input  logic [CNT_W-1:0] ARGA,
  input  logic [CNT_W-1:0] ARGB,
  input  logic             HOLD,
  output logic             GNTA,
  output logic             GNTB,
  output logic             DONE,
  output logic             DONE_ID,
  output logic             BUSY,
  output logic [CNT_W-1:0] Q
);

  state_e           state_q, state_d;
  logic             id_q, id_d;    // requester being served (0=A, 1=B)
  logic             ptr_q, ptr_d;  // side that wins a tie
  op_e              op_q, op_d;
  logic [CNT_W-1:0] arg_q, arg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;  // STEP cycles remaining after this one

  // Counter controls
  logic             ld, en, ps, cs;
  logic [CNT_W-1:0] d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    arg_d   = arg_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (REQA || REQB) begin
          id_d    = (REQA && REQB) ? ptr_q : REQB;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        op_d    = id_q ? op_e'(OPB) : op_e'(OPA);
        arg_d   = id_q ? ARGB : ARGA;
        cnt_d   = id_q ? ARGB : ARGA;
        // The side just served yields the next tie.
        ptr_d   = ~id_q;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q != OP_STEP) begin
          state_d = S_DONE;
        end else if (!HOLD) begin
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 4'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= S_IDLE;
      id_q    <= 1'b0;
      ptr_q   <= 1'b0;
      op_q    <= OP_CLEAR;
      arg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes come only from registered state/op, so they are one-hot or zero
  // and all low outside EXEC.
  logic exec;
  assign exec = (state_q == S_EXEC);
  assign cs   = exec && (op_q == OP_CLEAR);
  assign ps   = exec && (op_q == OP_PRESET);
  assign ld   = exec && (op_q == OP_LOAD);
  assign en   = exec && (op_q == OP_STEP) && !HOLD;
  assign d    = ld ? arg_q : '0;

  assign GNTA    = (state_q == S_GRANT) && !id_q;
  assign GNTB    = (state_q == S_GRANT) &&  id_q;
  assign DONE    = (state_q == S_DONE);
  assign DONE_ID = (state_q == S_DONE) &&  id_q;
  assign BUSY    = (state_q != S_IDLE);

  gray4_cnt u_cnt (
    .clk   (CLK),
    .rst_n (RN),
    .ps_i  (ps),
    .cs_i  (cs),
    .ld_i  (ld),
    .en_i  (en),
    .d_i   (d),
    .q_o   (Q)
  );

endmodule

// File: tb/tb_gray_cnt_arb.sv
// Directed bench for gray_cnt_arb: a table of single-requester commands with
// hand-computed results, then hand-written arbitration and reset sequences.
module tb_gray_cnt_arb;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       REQA = 1'b0, REQB = 1'b0;
  logic [1:0] OPA = 2'b00, OPB = 2'b00;
  logic [3:0] ARGA = 4'h0, ARGB = 4'h0;
  logic       HOLD = 1'b0;
  logic       GNTA, GNTB, DONE, DONE_ID, BUSY;
  logic [3:0] Q;

  int vectors = 0;
  int errors  = 0;

  gray_cnt_arb dut (
    .CLK(CLK), .RN(RN), .REQA(REQA), .REQB(REQB), .OPA(OPA), .OPB(OPB),
    .ARGA(ARGA), .ARGB(ARGB), .HOLD(HOLD), .GNTA(GNTA), .GNTB(GNTB),
    .DONE(DONE), .DONE_ID(DONE_ID), .BUSY(BUSY), .Q(Q)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic [1:0] op;
    logic [3:0] arg;
    int         hold_at;
    int         hold_len;
    logic [3:0] exp_q;
    int         exp_lat;   // negedges from grant to DONE
    int         exp_en;
    int         exp_strb;
  } vec_t;

  // Issue one command from a single requester and observe it to completion.
  task automatic do_cmd(input vec_t v, output int gnt_lat, output int done_lat,
                        output int en_cnt, output int strb_cnt, output logic multi,
                        output logic [3:0] q_done, output logic did, output logic [3:0] d_seen);
    logic got;
    logic seen;
    @(negedge CLK);
    if (v.id) begin REQB = 1'b1; OPB = v.op; ARGB = v.arg; end
    else      begin REQA = 1'b1; OPA = v.op; ARGA = v.arg; end
    got = 1'b0; gnt_lat = 0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge CLK);
      gnt_lat++;
      if (v.id ? GNTB : GNTA) got = 1'b1;
    end
    if (!got) gnt_lat = 99;
    REQA = 1'b0; REQB = 1'b0;
    en_cnt = 0; strb_cnt = 0; multi = 1'b0; done_lat = 0;
    q_done = 4'hx; did = 1'bx; d_seen = 4'h0; seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge CLK);
      done_lat++;
      HOLD = (c >= v.hold_at) && (c < v.hold_at + v.hold_len);
      #1;
      if (dut.en) en_cnt++;
      if (dut.ld || dut.en || dut.ps || dut.cs) strb_cnt++;
      if ($countones({dut.ld, dut.en, dut.ps, dut.cs}) > 1) multi = 1'b1;
      if (dut.ld) d_seen = dut.d;
      if (DONE) begin seen = 1'b1; q_done = Q; did = DONE_ID; end
    end
    HOLD = 1'b0;
    if (!seen) done_lat = 999;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RN = 1'b0; REQA = 1'b0; REQB = 1'b0; HOLD = 1'b0;
    @(negedge CLK);
    RN = 1'b1;
  endtask

  vec_t vecs[12];

  initial begin
    int gl, dl, enc, stc;
    logic mul, did_v;
    logic [3:0] qd, ds;
    logic order[4];
    int   when_c[4];
    int   n_gnt, done_cnt;
    logic both, busy1, busy4, got;

    //         id    op     arg    hat hlen exp_q  lat en strb
    vecs[0]  = '{1'b0, 2'b10, 4'h6, 0, 0, 4'b0110, 2, 0, 1};   // A LOAD 0110
    vecs[1]  = '{1'b0, 2'b00, 4'h0, 0, 0, 4'b0000, 2, 0, 1};   // A CLEAR
    vecs[2]  = '{1'b1, 2'b11, 4'h3, 0, 0, 4'b0110, 5, 4, 4};   // B STEP 4
    vecs[3]  = '{1'b0, 2'b10, 4'h9, 0, 0, 4'b1001, 2, 0, 1};   // A LOAD 1001
    vecs[4]  = '{1'b1, 2'b11, 4'h1, 0, 0, 4'b0000, 3, 2, 2};   // B STEP 2, wraps
    vecs[5]  = '{1'b0, 2'b01, 4'h0, 0, 0, 4'b1111, 2, 0, 1};   // A PRESET
    vecs[6]  = '{1'b1, 2'b00, 4'h0, 0, 0, 4'b0000, 2, 0, 1};   // B CLEAR
    vecs[7]  = '{1'b0, 2'b10, 4'h3, 0, 0, 4'b0011, 2, 0, 1};   // A LOAD 0011
    vecs[8]  = '{1'b1, 2'b11, 4'hF, 5, 3, 4'b0011, 20, 16, 16}; // B STEP 16, 3 HOLD
    vecs[9]  = '{1'b0, 2'b11, 4'h0, 0, 0, 4'b0010, 2, 1, 1};   // A STEP 1
    vecs[10] = '{1'b1, 2'b01, 4'h0, 0, 0, 4'b1111, 2, 0, 1};   // B PRESET
    vecs[11] = '{1'b0, 2'b11, 4'h2, 0, 0, 4'b1011, 4, 3, 3};   // A STEP 3

    // Reset state, observed while RN is still low.
    #1;
    check("rst_gnta", GNTA, 0);
    check("rst_gntb", GNTB, 0);
    check("rst_done", {DONE, DONE_ID}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_q", Q, 4'b0000);
    check("rst_strobes", {dut.ld, dut.en, dut.ps, dut.cs, dut.d}, 0);
    @(negedge CLK);
    RN = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i], gl, dl, enc, stc, mul, qd, did_v, ds);
      check($sformatf("v%0d_gnt_lat", i), gl, 1);
      check($sformatf("v%0d_done_lat", i), dl, vecs[i].exp_lat);
      check($sformatf("v%0d_en_cnt", i), enc, vecs[i].exp_en);
      check($sformatf("v%0d_strobes", i), stc, vecs[i].exp_strb);
      check($sformatf("v%0d_onehot", i), mul, 0);
      check($sformatf("v%0d_q", i), qd, vecs[i].exp_q);
      check($sformatf("v%0d_done_id", i), did_v, vecs[i].id);
      if (vecs[i].op == 2'b10) check($sformatf("v%0d_ld_d", i), ds, vecs[i].arg);
    end

    // Simultaneous, continuously held requests alternate starting with A.
    apply_reset();
    @(negedge CLK);
    OPA = 2'b00; OPB = 2'b00; REQA = 1'b1; REQB = 1'b1;
    n_gnt = 0; both = 1'b0; busy1 = 1'b0; busy4 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CLK);
      if (GNTA && GNTB) both = 1'b1;
      if (GNTA || GNTB) begin
        if (n_gnt < 4) begin order[n_gnt] = GNTB; when_c[n_gnt] = c; end
        n_gnt++;
      end
      if (c == 1) busy1 = BUSY;
      if (c == 4) busy4 = BUSY;
    end
    REQA = 1'b0; REQB = 1'b0;
    check("rr_count", n_gnt, 4);
    for (int g = 0; g < 4; g++) begin
      check($sformatf("rr_order%0d", g), order[g], g % 2);
      check($sformatf("rr_when%0d", g), when_c[g], 1 + 4 * g);
    end
    check("rr_no_double_grant", both, 0);
    check("busy_in_grant", busy1, 1);
    check("busy_back_idle", busy4, 0);
    repeat (2) @(negedge CLK);

    // A requests continuously; B arrives later and is served next.
    REQA = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c == 5) begin
        check("starve_a_second", GNTA, 1);
        REQB = 1'b1;
      end
      if (c == 9)  check("starve_b_grant", {GNTA, GNTB}, 2'b01);
      if (c == 11) check("starve_b_done", {DONE, DONE_ID}, 2'b11);
    end
    REQA = 1'b0; REQB = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset in the middle of an A STEP aborts it and returns the pointer to A.
    @(negedge CLK);
    REQA = 1'b1; OPA = 2'b11; ARGA = 4'hF;
    got = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(negedge CLK);
      if (GNTA) got = 1'b1;
    end
    check("abort_grant_seen", got, 1);
    REQA = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort_q_before", Q, 4'b0011);
    RN = 1'b0;
    #1;
    check("abort_q_zero", Q, 4'b0000);
    check("abort_outputs", {GNTA, GNTB, DONE, DONE_ID, BUSY}, 0);
    check("abort_strobes", {dut.ld, dut.en, dut.ps, dut.cs}, 0);
    done_cnt = 0;
    repeat (3) begin @(negedge CLK); if (DONE) done_cnt++; end
    RN = 1'b1;
    repeat (3) begin @(negedge CLK); if (DONE) done_cnt++; end
    check("abort_no_done", done_cnt, 0);

    REQA = 1'b1; OPA = 2'b10; ARGA = 4'b0101;
    REQB = 1'b1; OPB = 2'b10; ARGB = 4'b1100;
    for (int c = 1; c <= 7; c++) begin
      @(negedge CLK);
      if (c == 1) begin check("post_rst_gnt_a", {GNTA, GNTB}, 2'b10); REQA = 1'b0; end
      if (c == 3) begin check("post_rst_done_a", {DONE, DONE_ID}, 2'b10); check("post_rst_q_a", Q, 4'b0101); end
      if (c == 5) begin check("post_rst_gnt_b", {GNTA, GNTB}, 2'b01); REQB = 1'b0; end
      if (c == 7) begin check("post_rst_done_b", {DONE, DONE_ID}, 2'b11); check("post_rst_q_b", Q, 4'b1100); end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
